// File: rtl/ex_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding, ALU,
// destination-register select, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int         DATA_W = 32,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic              clk,
  input  logic              reset,
  // ID/EX register
  input  logic              regwritee,
  input  logic              memtorege,
  input  logic              memwritee,
  input  logic              alusrce,
  input  logic              jumplinke,
  input  logic [1:0]        regdste,
  input  logic [2:0]        alucontrole,
  input  logic [DATA_W-1:0] rd1e,
  input  logic [DATA_W-1:0] rd2e,
  input  logic [DATA_W-1:0] signimme,
  input  logic [DATA_W-1:0] pcplus4e,
  input  logic [4:0]        rse,
  input  logic [4:0]        rte,
  input  logic [4:0]        rde,
  // hazard unit
  input  logic [1:0]        forwardae,
  input  logic [1:0]        forwardbe,
  input  logic [DATA_W-1:0] resultw,
  input  logic              stallm,
  input  logic              flushm,
  output logic [4:0]        writerege,
  // EX/MEM register
  output logic              regwritem,
  output logic              memtoregm,
  output logic              memwritem,
  output logic [DATA_W-1:0] aluoutm,
  output logic [DATA_W-1:0] writedatam,
  output logic [4:0]        writeregm,
  output logic              zerom
);

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic [4:0]        writereg;
    logic              zero;
  } exmem_t;

  logic [DATA_W-1:0] srcae, srcbe, writedatae;
  logic [DATA_W-1:0] alu_res, aluoute;
  exmem_t            exmem_d, exmem_q, bubble;

  // rse is only consumed by the hazard unit; it rides along for visibility.
  logic unused_rse;
  assign unused_rse = ^rse;

  // Forwarding muxes: 11 falls back to the register-file value.
  always_comb begin
    srcae = rd1e;
    case (forwardae)
      2'b01:   srcae = resultw;
      2'b10:   srcae = aluoutm;
      default: srcae = rd1e;
    endcase
  end

  always_comb begin
    writedatae = rd2e;
    case (forwardbe)
      2'b01:   writedatae = resultw;
      2'b10:   writedatae = aluoutm;
      default: writedatae = rd2e;
    endcase
  end

  assign srcbe = alusrce ? signimme : writedatae;

  always_comb begin
    alu_res = '0;
    case (alucontrole)
      3'b000:  alu_res = srcae & srcbe;
      3'b001:  alu_res = srcae | srcbe;
      3'b010:  alu_res = srcae + srcbe;
      3'b110:  alu_res = srcae - srcbe;
      3'b111:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(srcae) < $signed(srcbe))};
      default: alu_res = '0;
    endcase
  end

  assign aluoute = jumplinke ? pcplus4e : alu_res;

  always_comb begin
    writerege = 5'd0;
    case (regdste)
      2'b00:   writerege = rte;
      2'b01:   writerege = rde;
      2'b10:   writerege = RA_REG;
      default: writerege = 5'd0;
    endcase
  end

  // A bubble targets r0 with regwrite low, so it can never match a forward.
  always_comb begin
    bubble           = '0;
    bubble.zero      = 1'b1;
  end

  always_comb begin
    exmem_d           = '0;
    exmem_d.regwrite  = regwritee;
    exmem_d.memtoreg  = memtorege;
    exmem_d.memwrite  = memwritee;
    exmem_d.aluout    = aluoute;
    exmem_d.writedata = writedatae;
    exmem_d.writereg  = writerege;
    exmem_d.zero      = (aluoute == '0);
  end

  always_ff @(posedge clk) begin
    if (reset)        exmem_q <= bubble;
    else if (flushm)  exmem_q <= bubble;
    else if (!stallm) exmem_q <= exmem_d;
  end

  assign regwritem  = exmem_q.regwrite;
  assign memtoregm  = exmem_q.memtoreg;
  assign memwritem  = exmem_q.memwrite;
  assign aluoutm    = exmem_q.aluout;
  assign writedatam = exmem_q.writedata;
  assign writeregm  = exmem_q.writereg;
  assign zerom      = exmem_q.zero;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes the expected EX/MEM contents,
// a monitor pops and compares them after every rising edge.
module tb_ex_stage;
  logic        clk = 1'b1;
  logic        reset, regwritee, memtorege, memwritee, alusrce, jumplinke;
  logic [1:0]  regdste, forwardae, forwardbe;
  logic [2:0]  alucontrole;
  logic [31:0] rd1e, rd2e, signimme, pcplus4e, resultw;
  logic [4:0]  rse, rte, rde;
  logic        stallm, flushm;
  logic [4:0]  writerege, writeregm;
  logic        regwritem, memtoregm, memwritem, zerom;
  logic [31:0] aluoutm, writedatam;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw, mr, mw, z;
    logic [31:0] alu, wd;
    logic [4:0]  wr, wre;
  } exp_t;

  exp_t sb[$];
  exp_t mdl;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(32), .RA_REG(5'd31)) dut (
    .clk(clk), .reset(reset),
    .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
    .alusrce(alusrce), .jumplinke(jumplinke), .regdste(regdste),
    .alucontrole(alucontrole), .rd1e(rd1e), .rd2e(rd2e), .signimme(signimme),
    .pcplus4e(pcplus4e), .rse(rse), .rte(rte), .rde(rde),
    .forwardae(forwardae), .forwardbe(forwardbe), .resultw(resultw),
    .stallm(stallm), .flushm(flushm), .writerege(writerege),
    .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem),
    .aluoutm(aluoutm), .writedatam(writedatam), .writeregm(writeregm),
    .zerom(zerom)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference: forwarding picks, arithmetic on plain integers.
  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rd);
    if (f == 2'd1) return resultw;
    if (f == 2'd2) return mdl.alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd6: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd7: return (sa < sb_) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Compute expected outcome of the coming edge, push it, then advance to next negedge.
  task automatic cyc();
    exp_t e;
    logic [31:0] a, wd, b;
    logic [4:0]  wre;
    wre = (regdste == 2'd0) ? rte : (regdste == 2'd1) ? rde :
          (regdste == 2'd2) ? 5'd31 : 5'd0;
    a  = pick(forwardae, rd1e);
    wd = pick(forwardbe, rd2e);
    b  = alusrce ? signimme : wd;
    if (reset || flushm) begin
      e = '{rw:0, mr:0, mw:0, z:1, alu:0, wd:0, wr:0, wre:0};
    end else if (stallm) begin
      e = mdl;
    end else begin
      e.rw = regwritee; e.mr = memtorege; e.mw = memwritee;
      e.alu = jumplinke ? pcplus4e : ref_alu(a, b, alucontrole);
      e.wd = wd; e.wr = wre; e.z = (e.alu == 0);
    end
    e.wre = wre;
    mdl = e;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_in();
    reset = 0; stallm = 0; flushm = 0;
    regwritee = 0; memtorege = 0; memwritee = 0; alusrce = 0; jumplinke = 0;
    regdste = 0; forwardae = 0; forwardbe = 0; alucontrole = 0;
    rd1e = 0; rd2e = 0; signimme = 0; pcplus4e = 0; resultw = 0;
    rse = 0; rte = 0; rde = 0;
  endtask

  function automatic logic [31:0] rdata();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  task automatic rand_in();
    regwritee = 1'($urandom); memtorege = 1'($urandom); memwritee = 1'($urandom);
    alusrce = 1'($urandom); jumplinke = ($urandom_range(0, 7) == 0);
    regdste = 2'($urandom); forwardae = 2'($urandom); forwardbe = 2'($urandom);
    alucontrole = 3'($urandom);
    rd1e = rdata(); rd2e = rdata(); signimme = rdata(); pcplus4e = rdata();
    resultw = rdata(); rse = 5'($urandom); rte = 5'($urandom); rde = 5'($urandom);
  endtask

  // Monitor: compare everything one delta-safe step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("regwritem", 32'(regwritem), 32'(e.rw));
        chk("memtoregm", 32'(memtoregm), 32'(e.mr));
        chk("memwritem", 32'(memwritem), 32'(e.mw));
        chk("aluoutm", aluoutm, e.alu);
        chk("writedatam", writedatam, e.wd);
        chk("writeregm", 32'(writeregm), 32'(e.wr));
        chk("zerom", 32'(zerom), 32'(e.z));
        chk("writerege", 32'(writerege), 32'(e.wre));
      end
    end
  end

  initial begin
    mdl = '{rw:0, mr:0, mw:0, z:1, alu:0, wd:0, wr:0, wre:0};
    clear_in();
    reset = 1;
    @(negedge clk);
    // reset with flush/stall noise on the inputs
    stallm = 1; cyc(); flushm = 1; cyc();
    clear_in();
    // add 5+7 -> r9
    rd1e = 5; rd2e = 7; alucontrole = 3'b010; regdste = 2'b01; rde = 9; regwritee = 1; cyc();
    // produce aluoutm=100, then forward it and resultw into a SUB
    rd1e = 60; rd2e = 40; cyc();
    rd1e = 555; resultw = 3; forwardae = 2'b10; forwardbe = 2'b01; alucontrole = 3'b110; cyc();
    rd1e = 20; rd2e = 5; forwardae = 2'b11; forwardbe = 2'b00; cyc();
    // signed SLT both ways
    rd1e = 32'hFFFF_FFFF; rd2e = 1; forwardae = 0; alucontrole = 3'b111; cyc();
    rd1e = 1; rd2e = 32'hFFFF_FFFF; cyc();
    // jal
    jumplinke = 1; pcplus4e = 32'h0040_0010; regdste = 2'b10; cyc();
    jumplinke = 0; alucontrole = 3'b011; cyc();
    // stall three cycles with changing inputs, then stall+flush
    clear_in(); rd1e = 33; rd2e = 1; alucontrole = 3'b010; regwritee = 1; memwritee = 1; cyc();
    for (int i = 0; i < 3; i++) begin rand_in(); stallm = 1; cyc(); end
    rand_in(); stallm = 1; flushm = 1; cyc();
    // reset while stalled holding a store
    clear_in(); memwritee = 1; rd1e = 8; alucontrole = 3'b010; cyc();
    stallm = 1; cyc(); reset = 1; cyc();
    reset = 0; stallm = 0; rand_in(); cyc();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      reset  = ($urandom_range(0, 49) == 0);
      flushm = ($urandom_range(0, 11) == 0);
      stallm = ($urandom_range(0, 5) == 0);
      cyc();
    end
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
